// File: rtl/magnitude_iter.sv
// Iterative magnitude sqrt(x^2 + y^2): one-cycle exact square-sum followed by a
// restoring bit-serial square root, with a valid/accept handshake on both sides.
module magnitude_iter #(
  parameter int INPUT_BITS   = 16,
  parameter int SIGNED_INPUT = 0,
  parameter int ROUND        = 0,
  parameter int CHANNEL_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_ready,
  output logic                    input_accept,
  input  logic [INPUT_BITS-1:0]   input_1,
  input  logic [INPUT_BITS-1:0]   input_2,
  input  logic [CHANNEL_BITS-1:0] input_channel,
  output logic                    output_ready,
  input  logic                    output_accept,
  output logic [INPUT_BITS:0]     output_1,
  output logic [CHANNEL_BITS-1:0] output_channel,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int SQUARE_SUM_BITS = 2*INPUT_BITS+1;
  localparam int OUTPUT_BITS     = INPUT_BITS+1;
  localparam int REM_BITS        = OUTPUT_BITS+3;
  localparam int CNT_BITS        = $clog2(OUTPUT_BITS+1);

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, HOLD} state_t;

  // Handshakes: a transfer happens on a rising edge where valid (input_ready /
  // output_ready) and accept (input_accept / output_accept) are both high.
  state_t                       state_q;
  logic [INPUT_BITS-1:0]        mag_x_q, mag_y_q, mag_x_d, mag_y_d;
  logic [CHANNEL_BITS-1:0]      chan_q;
  logic [SQUARE_SUM_BITS-1:0]   square_sum_output, sum_d;
  logic                         square_sum_output_ready;
  logic [2*INPUT_BITS-1:0]      sq_x, sq_y;
  logic [2*OUTPUT_BITS-1:0]     radicand_q;
  logic [REM_BITS-1:0]          rem_q, rem_d, rem_shift, trial;
  logic [OUTPUT_BITS-1:0]       root_q, root_d, root_final;
  logic [CNT_BITS-1:0]          cnt_q;
  logic                         round_up, in_hs, out_hs;

  function automatic logic [INPUT_BITS-1:0] magnitude_of(input logic [INPUT_BITS-1:0] v);
    // The most negative value maps to 2^(INPUT_BITS-1), which still fits unsigned.
    if (SIGNED_INPUT != 0 && v[INPUT_BITS-1]) return ~v + 1'b1;
    return v;
  endfunction

  assign input_accept = (state_q == IDLE) || (state_q == HOLD && output_accept);
  assign in_hs        = input_ready && input_accept;
  assign out_hs       = output_ready && output_accept;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

  assign mag_x_d = magnitude_of(input_1);
  assign mag_y_d = magnitude_of(input_2);
  assign sq_x    = {{INPUT_BITS{1'b0}}, mag_x_q} * {{INPUT_BITS{1'b0}}, mag_x_q};
  assign sq_y    = {{INPUT_BITS{1'b0}}, mag_y_q} * {{INPUT_BITS{1'b0}}, mag_y_q};
  assign sum_d   = {1'b0, sq_x} + {1'b0, sq_y};

  // Restoring step: bring down the next two radicand bits, try subtracting 4r+1.
  assign rem_shift = {rem_q[REM_BITS-3:0], radicand_q[2*OUTPUT_BITS-1 -: 2]};
  assign trial     = {1'b0, root_q, 2'b01};

  always_comb begin
    rem_d  = rem_shift;
    root_d = {root_q[OUTPUT_BITS-2:0], 1'b0};
    if (rem_shift >= trial) begin
      rem_d  = rem_shift - trial;
      root_d = {root_q[OUTPUT_BITS-2:0], 1'b1};
    end
  end

  assign round_up   = (ROUND != 0) && (rem_q > {3'b000, root_q});
  assign root_final = root_q + OUTPUT_BITS'(round_up);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                 <= IDLE;
      mag_x_q                 <= '0;
      mag_y_q                 <= '0;
      chan_q                  <= '0;
      square_sum_output       <= '0;
      square_sum_output_ready <= 1'b0;
      radicand_q              <= '0;
      rem_q                   <= '0;
      root_q                  <= '0;
      cnt_q                   <= '0;
      output_ready            <= 1'b0;
      output_1                <= '0;
      output_channel          <= '0;
    end else begin
      square_sum_output_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_hs) begin
            mag_x_q <= mag_x_d;
            mag_y_q <= mag_y_d;
            chan_q  <= input_channel;
            state_q <= SQUARE;
          end
        end
        SQUARE: begin
          square_sum_output       <= sum_d;
          square_sum_output_ready <= 1'b1;
          radicand_q              <= {1'b0, sum_d};
          rem_q                   <= '0;
          root_q                  <= '0;
          cnt_q                   <= '0;
          state_q                 <= ROOT;
        end
        ROOT: begin
          // OUTPUT_BITS iteration cycles, then one cycle to round and publish.
          if (cnt_q == CNT_BITS'(OUTPUT_BITS)) begin
            output_1       <= root_final;
            output_channel <= chan_q;
            output_ready   <= 1'b1;
            state_q        <= HOLD;
          end else begin
            rem_q      <= rem_d;
            root_q     <= root_d;
            radicand_q <= radicand_q << 2;
            cnt_q      <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_hs) begin
            output_ready <= 1'b0;
            if (in_hs) begin
              mag_x_q <= mag_x_d;
              mag_y_q <= mag_y_d;
              chan_q  <= input_channel;
              state_q <= SQUARE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_iter.sv
// Bench for magnitude_iter: three instances (floor, rounded, signed) share stimulus
// and are checked against an arithmetic square-root model.
module tb_magnitude_iter;

  localparam int IB = 16;
  localparam int OB = IB + 1;
  localparam int CB = 2;
  localparam int EW = CB + 3*OB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          input_ready = 1'b0;
  logic          output_accept = 1'b1;
  logic [IB-1:0] in1 = '0, in2 = '0;
  logic [CB-1:0] in_ch = '0;

  logic          acc_u, acc_r, acc_s, rdy_u, rdy_r, rdy_s, busy_u, busy_r, busy_s;
  logic [OB-1:0] out_u, out_r, out_s;
  logic [CB-1:0] ch_u, ch_r, ch_s;
  logic [1:0]    st_u, st_r, st_s;

  int checks = 0;
  int passed = 0;

  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  magnitude_iter dut_u (
    .clk(clk), .rst(rst), .input_ready(input_ready), .input_accept(acc_u),
    .input_1(in1), .input_2(in2), .input_channel(in_ch), .output_ready(rdy_u),
    .output_accept(output_accept), .output_1(out_u), .output_channel(ch_u),
    .busy(busy_u), .dbg_state(st_u));

  magnitude_iter #(.ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .input_ready(input_ready), .input_accept(acc_r),
    .input_1(in1), .input_2(in2), .input_channel(in_ch), .output_ready(rdy_r),
    .output_accept(output_accept), .output_1(out_r), .output_channel(ch_r),
    .busy(busy_r), .dbg_state(st_r));

  magnitude_iter #(.SIGNED_INPUT(1)) dut_s (
    .clk(clk), .rst(rst), .input_ready(input_ready), .input_accept(acc_s),
    .input_1(in1), .input_2(in2), .input_channel(in_ch), .output_ready(rdy_s),
    .output_accept(output_accept), .output_1(out_s), .output_channel(ch_s),
    .busy(busy_s), .dbg_state(st_s));

  // Reference model: plain integer arithmetic and a binary-search square root.
  function automatic longint model_sum(input logic [IB-1:0] x, input logic [IB-1:0] y, input bit sgn);
    longint ax, ay;
    ax = sgn ? longint'($signed(x)) : longint'(x);
    ay = sgn ? longint'($signed(y)) : longint'(y);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    return ax*ax + ay*ay;
  endfunction

  function automatic logic [OB-1:0] model_mag(input longint s, input bit rnd);
    longint lo, hi, mid;
    lo = 0;
    hi = 200000;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid*mid <= s) lo = mid;
      else hi = mid - 1;
    end
    if (rnd && (s - lo*lo) > lo) lo = lo + 1;
    return lo[OB-1:0];
  endfunction

  function automatic logic [EW-1:0] expect_all(input logic [IB-1:0] x, input logic [IB-1:0] y,
                                               input logic [CB-1:0] ch);
    return {ch, model_mag(model_sum(x, y, 1'b0), 1'b0), model_mag(model_sum(x, y, 1'b0), 1'b1),
            model_mag(model_sum(x, y, 1'b1), 1'b0)};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    input_ready = 1'b1;
    in1 = 16'd3; in2 = 16'd4; in_ch = 2'd1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_u !== 1'b0 || rdy_r !== 1'b0 || rdy_s !== 1'b0) $display("FAIL reset_ready: got %b%b%b want 000", rdy_u, rdy_r, rdy_s); else passed++;
    checks++; if (out_u !== '0 || out_r !== '0 || out_s !== '0) $display("FAIL reset_output: got %0d %0d %0d want 0", out_u, out_r, out_s); else passed++;
    checks++; if (ch_u !== '0) $display("FAIL reset_channel: got %0d want 0", ch_u); else passed++;
    checks++; if (busy_u !== 1'b0 || busy_r !== 1'b0 || busy_s !== 1'b0) $display("FAIL reset_busy: got %b%b%b want 000", busy_u, busy_r, busy_s); else passed++;
    checks++; if (dut_u.square_sum_output !== '0) $display("FAIL reset_sum: got %0d want 0", dut_u.square_sum_output); else passed++;
    checks++; if (dut_u.square_sum_output_ready !== 1'b0) $display("FAIL reset_sum_ready: got %b want 0", dut_u.square_sum_output_ready); else passed++;
    checks++; if (st_u !== 2'd0 || st_r !== 2'd0 || st_s !== 2'd0) $display("FAIL reset_state: got %0d want 0", st_u); else passed++;
    rst = 1'b0;
    input_ready = 1'b0;
    #1;
    checks++; if (acc_u !== 1'b1) $display("FAIL reset_accept: got %b want 1", acc_u); else passed++;
    @(negedge clk);
    checks++; if (busy_u !== 1'b0) $display("FAIL reset_no_capture: busy got %b want 0", busy_u); else passed++;
  endtask

  task automatic run_one(input logic [IB-1:0] x, input logic [IB-1:0] y, input logic [CB-1:0] ch);
    logic [EW-1:0] e;
    longint su, ss;
    int k, pulses;
    e = expect_all(x, y, ch);
    su = model_sum(x, y, 1'b0);
    ss = model_sum(x, y, 1'b1);
    pulses = 0;
    @(negedge clk);
    in1 = x; in2 = y; in_ch = ch; input_ready = 1'b1; output_accept = 1'b1;
    #1;
    checks++; if (acc_u !== 1'b1) $display("FAIL run_accept: got %b want 1", acc_u); else passed++;
    @(posedge clk);
    @(negedge clk);
    input_ready = 1'b0;
    in1 = IB'($urandom); in2 = IB'($urandom); in_ch = CB'($urandom);
    k = 0;
    while (rdy_u !== 1'b1 && k < 40) begin
      if (dut_u.square_sum_output_ready === 1'b1) begin
        pulses++;
        checks++; if (k != 1) $display("FAIL sum_pulse_time: got %0d want 1", k); else passed++;
        checks++; if (dut_u.square_sum_output !== su[2*IB:0]) $display("FAIL square_sum: got %0d want %0d", dut_u.square_sum_output, su); else passed++;
        checks++; if (dut_s.square_sum_output !== ss[2*IB:0]) $display("FAIL square_sum_signed: got %0d want %0d", dut_s.square_sum_output, ss); else passed++;
      end
      @(negedge clk);
      k++;
    end
    checks++; if (k != OB + 2) $display("FAIL latency: got %0d want %0d", k, OB + 2); else passed++;
    checks++; if (pulses != 1) $display("FAIL sum_pulse_count: got %0d want 1", pulses); else passed++;
    checks++; if (rdy_r !== 1'b1 || rdy_s !== 1'b1) $display("FAIL ready_rs: got %b%b want 11", rdy_r, rdy_s); else passed++;
    checks++; if (out_u !== e[3*OB-1 -: OB]) $display("FAIL mag_floor: x=%0d y=%0d got %0d want %0d", x, y, out_u, e[3*OB-1 -: OB]); else passed++;
    checks++; if (out_r !== e[2*OB-1 -: OB]) $display("FAIL mag_round: x=%0d y=%0d got %0d want %0d", x, y, out_r, e[2*OB-1 -: OB]); else passed++;
    checks++; if (out_s !== e[OB-1:0]) $display("FAIL mag_signed: x=%0d y=%0d got %0d want %0d", x, y, out_s, e[OB-1:0]); else passed++;
    checks++; if (ch_u !== ch || ch_s !== ch) $display("FAIL channel: got %0d want %0d", ch_u, ch); else passed++;
    @(negedge clk);
    checks++; if (rdy_u !== 1'b0 || busy_u !== 1'b0) $display("FAIL drain: ready %b busy %b want 0 0", rdy_u, busy_u); else passed++;
  endtask

  task automatic test_directed;
    logic [IB-1:0] tx[7], ty[7];
    logic [OB-1:0] eu[7], er[7], es[7];
    tx[0] = 16'd3;     ty[0] = 16'd4;     eu[0] = 17'd5;     er[0] = 17'd5;     es[0] = 17'd5;
    tx[1] = 16'hFFFF;  ty[1] = 16'hFFFF;  eu[1] = 17'd92680; er[1] = 17'd92680; es[1] = 17'd1;
    tx[2] = 16'd2;     ty[2] = 16'd2;     eu[2] = 17'd2;     er[2] = 17'd3;     es[2] = 17'd2;
    tx[3] = 16'd1;     ty[3] = 16'd1;     eu[3] = 17'd1;     er[3] = 17'd1;     es[3] = 17'd1;
    tx[4] = 16'h8000;  ty[4] = 16'd0;     eu[4] = 17'd32768; er[4] = 17'd32768; es[4] = 17'd32768;
    tx[5] = 16'hFFFD;  ty[5] = 16'hFFFC;  eu[5] = 17'd92676; er[5] = 17'd92677; es[5] = 17'd5;
    tx[6] = 16'd0;     ty[6] = 16'd0;     eu[6] = 17'd0;     er[6] = 17'd0;     es[6] = 17'd0;
    for (int i = 0; i < 7; i++) begin
      run_one(tx[i], ty[i], 2'(i + 2));
      checks++; if (out_u !== eu[i] || out_r !== er[i] || out_s !== es[i])
        $display("FAIL directed_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, out_u, out_r, out_s, eu[i], er[i], es[i]);
      else passed++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) run_one(IB'($urandom), IB'($urandom), CB'($urandom));
  endtask

  task automatic test_backpressure;
    logic [IB-1:0] ax, ay, bx, by;
    logic [EW-1:0] ea, eb;
    int k;
    ax = IB'($urandom); ay = IB'($urandom); bx = IB'($urandom); by = IB'($urandom);
    ea = expect_all(ax, ay, 2'd1);
    eb = expect_all(bx, by, 2'd2);
    @(negedge clk);
    in1 = ax; in2 = ay; in_ch = 2'd1; input_ready = 1'b1; output_accept = 1'b0;
    @(posedge clk);
    @(negedge clk);
    input_ready = 1'b0;
    k = 0;
    while (rdy_u !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++; if (k != OB + 2) $display("FAIL bp_latency: got %0d want %0d", k, OB + 2); else passed++;
    in1 = bx; in2 = by; in_ch = 2'd2; input_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (rdy_u !== 1'b1 || out_u !== ea[3*OB-1 -: OB] || ch_u !== 2'd1 || out_r !== ea[2*OB-1 -: OB])
        $display("FAIL bp_hold_%0d: got rdy %b out %0d ch %0d want 1 %0d 1", i, rdy_u, out_u, ch_u, ea[3*OB-1 -: OB]);
      else passed++;
      checks++; if (acc_u !== 1'b0) $display("FAIL bp_accept_low_%0d: got %b want 0", i, acc_u); else passed++;
      @(negedge clk);
    end
    output_accept = 1'b1;
    #1;
    checks++; if (acc_u !== 1'b1) $display("FAIL bp_same_edge_accept: got %b want 1", acc_u); else passed++;
    @(posedge clk);
    @(negedge clk);
    input_ready = 1'b0;
    checks++; if (rdy_u !== 1'b0 || busy_u !== 1'b1) $display("FAIL bp_handover: ready %b busy %b want 0 1", rdy_u, busy_u); else passed++;
    k = 0;
    while (rdy_u !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++; if (k != OB + 2) $display("FAIL bp_second_latency: got %0d want %0d", k, OB + 2); else passed++;
    checks++; if (out_u !== eb[3*OB-1 -: OB] || out_s !== eb[OB-1:0] || ch_u !== 2'd2)
      $display("FAIL bp_second: got %0d %0d ch %0d want %0d %0d 2", out_u, out_s, ch_u, eb[3*OB-1 -: OB], eb[OB-1:0]);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [EW-1:0] e;
    int sent, got;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 4000 && got < 30; cyc++) begin
      @(negedge clk);
      input_ready = (sent < 30) && ($urandom_range(0, 3) != 0);
      in1 = ($urandom_range(0, 5) == 0) ? 16'hFFFF : IB'($urandom);
      in2 = IB'($urandom);
      in_ch = CB'($urandom);
      output_accept = ($urandom_range(0, 2) != 0);
      #1;
      if (rdy_u === 1'b1 && output_accept) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_unexpected: got output %0d want none", out_u);
        end else begin
          e = exp_q.pop_front();
          if (out_u !== e[3*OB-1 -: OB] || out_r !== e[2*OB-1 -: OB] || out_s !== e[OB-1:0] || ch_u !== e[EW-1 -: CB])
            $display("FAIL b2b_%0d: got %0d/%0d/%0d ch %0d want %0d/%0d/%0d ch %0d", got, out_u, out_r, out_s, ch_u,
                     e[3*OB-1 -: OB], e[2*OB-1 -: OB], e[OB-1:0], e[EW-1 -: CB]);
          else passed++;
        end
        got++;
      end
      if (input_ready && acc_u === 1'b1) begin
        exp_q.push_back(expect_all(in1, in2, in_ch));
        sent++;
      end
    end
    input_ready = 1'b0;
    output_accept = 1'b1;
    checks++; if (got != 30 || exp_q.size() != 0) $display("FAIL b2b_count: got %0d left %0d want 30 0", got, exp_q.size()); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_root;
    int seen;
    @(negedge clk);
    in1 = 16'd100; in2 = 16'd200; in_ch = 2'd1; input_ready = 1'b1; output_accept = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_ready = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rdy_u !== 1'b0 || busy_u !== 1'b0) $display("FAIL mid_reset: ready %b busy %b want 0 0", rdy_u, busy_u); else passed++;
    checks++; if (out_u !== '0 || ch_u !== '0 || dut_u.square_sum_output !== '0) $display("FAIL mid_reset_regs: out %0d ch %0d sum %0d want 0", out_u, ch_u, dut_u.square_sum_output); else passed++;
    @(negedge clk);
    checks++; if (acc_u !== 1'b1) $display("FAIL mid_reset_accept: got %b want 1", acc_u); else passed++;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rdy_u === 1'b1 || rdy_r === 1'b1 || rdy_s === 1'b1) seen++;
    end
    checks++; if (seen != 0) $display("FAIL mid_reset_discard: got %0d ready cycles want 0", seen); else passed++;
    run_one(16'd6, 16'd8, 2'd3);
    checks++; if (out_u !== 17'd10) $display("FAIL after_reset_sample: got %0d want 10", out_u); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_in_root();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
